// File: rtl/stg2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : stg2_pkg                                                   |
// | Shared types and widths for the stage-2 scheduler slice.             |
// |   state_t : scheduler FSM states (IDLE/ISSUE/WAIT/HOLD)              |
// |   STG1_W  : stage-1 word width                                       |
// |   KEY_W   : key width                                                |
// |   STG2_W  : stage-2 result width                                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package stg2_pkg;

  localparam int STG1_W = 16;
  localparam int KEY_W  = 5;
  localparam int STG2_W = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stg2_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : stg2_sched_if                                            |
// | Bundles the requester, datapath and result signals of stg2_sched.    |
// |   req_valid/req_data/req_key/req_ready : per-requester handshake     |
// |   dp_in/dp_key/dp_start/dp_done/dp_out : shared stage-2 datapath     |
// |   res_valid/res_data/res_id/res_ready  : tagged result handshake     |
// |   err                                  : sticky timeout flag         |
// | Modports : master = scheduler view, slave = environment view         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface stg2_sched_if #(
  parameter int NREQ = 2
);
  import stg2_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [STG1_W*NREQ-1:0] req_data;
  logic [KEY_W*NREQ-1:0]  req_key;
  logic [NREQ-1:0]        req_ready;
  logic [STG1_W-1:0]      dp_in;
  logic [KEY_W-1:0]       dp_key;
  logic                   dp_start;
  logic                   dp_done;
  logic [STG2_W-1:0]      dp_out;
  logic                   res_valid;
  logic [STG2_W-1:0]      res_data;
  logic [IDW-1:0]         res_id;
  logic                   res_ready;
  logic                   err;

  modport master (
    input  req_valid, req_data, req_key, dp_done, dp_out, res_ready,
    output req_ready, dp_in, dp_key, dp_start, res_valid, res_data, res_id, err
  );

  modport slave (
    output req_valid, req_data, req_key, dp_done, dp_out, res_ready,
    input  req_ready, dp_in, dp_key, dp_start, res_valid, res_data, res_id, err
  );

endinterface
`default_nettype wire

// File: rtl/stg2_sched_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_pick                                                   |
// | Combinational round-robin search: first valid requester at or above  |
// | ptr, wrapping modulo NREQ.                                           |
// |   req_valid_i : per-requester pending flags                          |
// |   ptr_i       : highest-priority index (0..NREQ-1)                   |
// |   grant_o     : one-hot winner (zero when nothing is valid)          |
// |   idx_o       : binary index of the winner                           |
// |   any_o       : at least one requester is valid                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int j;

  // Walk the offsets from farthest to nearest so the nearest valid
  // requester (lowest offset from ptr) is the last one written and wins.
  // ptr never exceeds NREQ-1, so one subtraction is enough to wrap.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stg2_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stg2_sched                                                |
// | Round-robin scheduler sharing one stage-2 datapath between NREQ      |
// | requesters. Accepts a word+key, pulses dp_start for one cycle,       |
// | captures dp_out on dp_done and returns it tagged with the requester. |
// |   clk2 : clock, rising edge                                          |
// |   rst  : asynchronous active-high reset                              |
// |   bus  : stg2_sched_if.master (requests, datapath, result, err)      |
// | Option   : STG2_SCHED_TIMEOUT_EN - abort WAIT after TIMEOUT_CYC      |
// |            cycles without dp_done, returning 0 and setting err.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module stg2_sched
  import stg2_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 15,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic         clk2,
  input  logic         rst,
  stg2_sched_if.master bus
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("stg2_sched: NREQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [STG1_W-1:0]   dp_in_q, dp_in_d;
  logic [KEY_W-1:0]    dp_key_q, dp_key_d;
  logic [IDW-1:0]      res_id_q, res_id_d;
  logic [STG2_W-1:0]   res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;

  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_idx;
  logic                w_any;

`ifdef STG2_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_valid_i (bus.req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (w_grant),
    .idx_o       (w_idx),
    .any_o       (w_any)
  );

  // Grant is only offered while idle; the picker already returns zero
  // when no requester is valid.
  assign bus.req_ready = (state_q == IDLE) ? w_grant : '0;
  assign bus.dp_start  = (state_q == ISSUE);
  assign bus.dp_in     = dp_in_q;
  assign bus.dp_key    = dp_key_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

`ifdef STG2_SCHED_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dp_in_d     = dp_in_q;
    dp_key_d    = dp_key_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
`ifdef STG2_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Any valid requester implies a grant, so valid&ready is w_any.
        if (w_any) begin
          dp_in_d  = bus.req_data[int'(w_idx)*STG1_W +: STG1_W];
          dp_key_d = bus.req_key[int'(w_idx)*KEY_W +: KEY_W];
          res_id_d = w_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef STG2_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // dp_done is sticky in the datapath; it is trusted here because
        // stage 2 registered its result on the ISSUE edge.
        if (bus.dp_done) begin
          res_data_d  = bus.dp_out;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
`ifdef STG2_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d       = 1'b1;
          res_data_d  = '0;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          // Explicit wrap so non-power-of-two NREQ never reaches NREQ.
          ptr_d       = (res_id_q == IDW'(NREQ - 1)) ? '0 : res_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      dp_in_q     <= '0;
      dp_key_q    <= '0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dp_in_q     <= dp_in_d;
      dp_key_q    <= dp_key_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef STG2_SCHED_TIMEOUT_EN
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule
`default_nettype wire
